// File: rtl/ce_opnd_dist_pkg.sv
// Shared constants and helpers for the RALU -> coprocessor-engine operand distributor.
// Queue payload layout, LSB first: A operand, B operand, opcode, active-high 32-bit mode flag.
package ce_opnd_dist_pkg;

    localparam int CE_DW_DEF  = 32;
    localparam int CE_OPW_DEF = 12;

    typedef enum logic [1:0] {
        Q_EMPTY,
        Q_PARTIAL,
        Q_FULL
    } q_state_e;

    function automatic int payload_w(input int dw, input int opw);
        return 2 * dw + opw + 1;
    endfunction

endpackage

// File: rtl/ce_opnd_dist_opfifo.sv
// One DEPTH-entry operation queue for a single coprocessor engine.
// Head is storage[rdptr], registered only; a push is never visible on the same cycle.
module ce_opnd_dist_opfifo
    import ce_opnd_dist_pkg::*;
#(
    parameter int W     = 77,
    parameter int DEPTH = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic         vld_o,
    output logic         full_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    q_state_e      state;
    logic          do_push, do_pop;

    always_comb begin
        if (cnt_q == '0)                   state = Q_EMPTY;
        else if (cnt_q == (AW + 1)'(DEPTH)) state = Q_FULL;
        else                               state = Q_PARTIAL;
    end

    assign full_o  = (state == Q_FULL);
    assign vld_o   = (state != Q_EMPTY);
    assign head_o  = mem_q[rd_q];
    // A full queue refuses pushes, so a full queue never passes an op straight through.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & vld_o;

    always_comb begin
        wr_d  = do_push ? wr_q + 1'b1 : wr_q;
        rd_d  = do_pop  ? rd_q + 1'b1 : rd_q;
        cnt_d = cnt_q;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) mem_q[wr_q] <= data_i;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ce_opnd_dist.sv
// Operand/opcode distributor from the RALU to NUM_CE coprocessor engines, one queue per engine.
// Optional per-engine pop counters are built when CE_DIST_PERF_EN is defined.
module ce_opnd_dist
    import ce_opnd_dist_pkg::*;
#(
    parameter int NUM_CE = 2,
    parameter int DW     = CE_DW_DEF,
    parameter int OPW    = CE_OPW_DEF,
    parameter int DEPTH  = 2,
    parameter int SELW   = 3,
    parameter int CNTW   = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DW-1:0]         RALU_CINA_E_R,
    input  logic [DW-1:0]         RALU_CINBI_E_R,
    input  logic [OPW-1:0]        RALU_CEOP_S_R,
    input  logic                  RALU_INSTM32_S_R_N,
    input  logic [SELW-1:0]       RALU_CESEL_E_R,
    input  logic                  RALU_CEBCAST_E_R,
    input  logic                  RALU_CEVLD_E_R,
    output logic                  CEI_CERDY_E_R,
    output logic [NUM_CE*DW-1:0]  CEI_AOP_E_R,
    output logic [NUM_CE*DW-1:0]  CEI_BOP_E_R,
    output logic [NUM_CE*OPW-1:0] CEI_CEOP_S_R,
    output logic [NUM_CE-1:0]     CEI_INSTM32_S_R_N,
    output logic [NUM_CE-1:0]     CEI_CEVLD_E_R,
    input  logic [NUM_CE-1:0]     CE_ACK_E_R,
    output logic [DW-1:0]         CEI_CEHLW_AOP_E_R,
`ifdef CE_DIST_PERF_EN
    output logic                  CEI_SELERR_R,
    output logic [NUM_CE*CNTW-1:0] CEI_PERFCNT_R
`else
    output logic                  CEI_SELERR_R
`endif
);
    localparam int PW = payload_w(DW, OPW);

    logic [NUM_CE-1:0] full, push, pop;
    logic              any_full, sel_full, sel_ok, accept;
    logic [PW-1:0]     payload;
    logic [DW-1:0]     hlw_q, hlw_d;
    logic              selerr_q, selerr_d;

    always_comb begin
        any_full = |full;
        sel_full = 1'b0;
        for (int i = 0; i < NUM_CE; i++)
            if (RALU_CESEL_E_R == SELW'(i)) sel_full = full[i];
    end

    assign sel_ok = (32'(RALU_CESEL_E_R) < NUM_CE);
    // Out-of-range selects are always "ready" so the RALU never stalls on a bad index.
    assign CEI_CERDY_E_R = RALU_CEBCAST_E_R ? ~any_full : (sel_ok ? ~sel_full : 1'b1);
    assign accept  = RALU_CEVLD_E_R & CEI_CERDY_E_R;
    // Flag stored active-high so cleared storage reads back as INSTM32_N = 1.
    assign payload = {~RALU_INSTM32_S_R_N, RALU_CEOP_S_R, RALU_CINBI_E_R, RALU_CINA_E_R};

    for (genvar i = 0; i < NUM_CE; i++) begin : g_ce
        logic [PW-1:0] head;

        assign push[i] = accept & (RALU_CEBCAST_E_R | (sel_ok & (RALU_CESEL_E_R == SELW'(i))));
        assign pop[i]  = CEI_CEVLD_E_R[i] & CE_ACK_E_R[i];

        ce_opnd_dist_opfifo #(.W(PW), .DEPTH(DEPTH)) u_fifo (
            .clk_i  (CLK),
            .rst_i  (RST),
            .push_i (push[i]),
            .data_i (payload),
            .pop_i  (pop[i]),
            .head_o (head),
            .vld_o  (CEI_CEVLD_E_R[i]),
            .full_o (full[i])
        );

        assign CEI_AOP_E_R[i*DW +: DW]    = head[DW-1:0];
        assign CEI_BOP_E_R[i*DW +: DW]    = head[2*DW-1:DW];
        assign CEI_CEOP_S_R[i*OPW +: OPW] = head[2*DW +: OPW];
        assign CEI_INSTM32_S_R_N[i]       = ~head[PW-1];

`ifdef CE_DIST_PERF_EN
        logic [CNTW-1:0] perf_q, perf_d;

        assign perf_d = (pop[i] && !(&perf_q)) ? perf_q + 1'b1 : perf_q;

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) perf_q <= '0;
            else     perf_q <= perf_d;
        end

        assign CEI_PERFCNT_R[i*CNTW +: CNTW] = perf_q;
`endif
    end

`ifndef CE_DIST_PERF_EN
    logic [CNTW-1:0] unused_cntw;
    assign unused_cntw = '0;
`endif

    assign hlw_d    = accept ? RALU_CINA_E_R : hlw_q;
    assign selerr_d = selerr_q | (accept & ~RALU_CEBCAST_E_R & ~sel_ok);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hlw_q    <= '0;
            selerr_q <= 1'b0;
        end else begin
            hlw_q    <= hlw_d;
            selerr_q <= selerr_d;
        end
    end

    assign CEI_CEHLW_AOP_E_R = hlw_q;
    assign CEI_SELERR_R      = selerr_q;

endmodule

// File: tb/tb_ce_opnd_dist.sv
// Self-checking bench for ce_opnd_dist: directed scenario tasks plus a per-engine scoreboard monitor.
// Define CE_DIST_PERF_EN to also exercise the pop counters.
module tb_ce_opnd_dist;
    localparam int NUM_CE = 2;
    localparam int DW     = 32;
    localparam int OPW    = 12;
    localparam int DEPTH  = 2;
    localparam int SELW   = 3;
    localparam int CNTW   = 16;
    localparam int PW     = 2 * DW + OPW + 1;

    typedef logic [PW-1:0] pl_t;

    logic                  CLK = 1'b0;
    logic                  RST = 1'b1;
    logic [DW-1:0]         RALU_CINA_E_R = '0;
    logic [DW-1:0]         RALU_CINBI_E_R = '0;
    logic [OPW-1:0]        RALU_CEOP_S_R = '0;
    logic                  RALU_INSTM32_S_R_N = 1'b1;
    logic [SELW-1:0]       RALU_CESEL_E_R = '0;
    logic                  RALU_CEBCAST_E_R = 1'b0;
    logic                  RALU_CEVLD_E_R = 1'b0;
    logic                  CEI_CERDY_E_R;
    logic [NUM_CE*DW-1:0]  CEI_AOP_E_R;
    logic [NUM_CE*DW-1:0]  CEI_BOP_E_R;
    logic [NUM_CE*OPW-1:0] CEI_CEOP_S_R;
    logic [NUM_CE-1:0]     CEI_INSTM32_S_R_N;
    logic [NUM_CE-1:0]     CEI_CEVLD_E_R;
    logic [NUM_CE-1:0]     CE_ACK_E_R = '0;
    logic [DW-1:0]         CEI_CEHLW_AOP_E_R;
    logic                  CEI_SELERR_R;
`ifdef CE_DIST_PERF_EN
    logic [NUM_CE*CNTW-1:0] CEI_PERFCNT_R;
`endif

    int checks = 0;
    int failures = 0;

    pl_t           sbq [NUM_CE][$];
    logic [DW-1:0] exp_hlw = '0;
    logic          exp_selerr = 1'b0;
    logic [CNTW-1:0] pcnt [NUM_CE];
    logic          m_rdy;
    pl_t           got, pl;

    ce_opnd_dist #(
        .NUM_CE(NUM_CE), .DW(DW), .OPW(OPW), .DEPTH(DEPTH), .SELW(SELW), .CNTW(CNTW)
    ) dut (
        .CLK                (CLK),
        .RST                (RST),
        .RALU_CINA_E_R      (RALU_CINA_E_R),
        .RALU_CINBI_E_R     (RALU_CINBI_E_R),
        .RALU_CEOP_S_R      (RALU_CEOP_S_R),
        .RALU_INSTM32_S_R_N (RALU_INSTM32_S_R_N),
        .RALU_CESEL_E_R     (RALU_CESEL_E_R),
        .RALU_CEBCAST_E_R   (RALU_CEBCAST_E_R),
        .RALU_CEVLD_E_R     (RALU_CEVLD_E_R),
        .CEI_CERDY_E_R      (CEI_CERDY_E_R),
        .CEI_AOP_E_R        (CEI_AOP_E_R),
        .CEI_BOP_E_R        (CEI_BOP_E_R),
        .CEI_CEOP_S_R       (CEI_CEOP_S_R),
        .CEI_INSTM32_S_R_N  (CEI_INSTM32_S_R_N),
        .CEI_CEVLD_E_R      (CEI_CEVLD_E_R),
        .CE_ACK_E_R         (CE_ACK_E_R),
        .CEI_CEHLW_AOP_E_R  (CEI_CEHLW_AOP_E_R),
`ifdef CE_DIST_PERF_EN
        .CEI_SELERR_R       (CEI_SELERR_R),
        .CEI_PERFCNT_R      (CEI_PERFCNT_R)
`else
        .CEI_SELERR_R       (CEI_SELERR_R)
`endif
    );

    always #5 CLK = ~CLK;

    // Scoreboard: evaluated mid-cycle, predicts what the coming rising edge does.
    always @(negedge CLK) begin
        if (RST) begin
            for (int e = 0; e < NUM_CE; e++) begin
                sbq[e].delete();
                pcnt[e] = '0;
            end
            exp_hlw    = '0;
            exp_selerr = 1'b0;
        end else begin
            if (RALU_CEBCAST_E_R) begin
                m_rdy = 1'b1;
                for (int e = 0; e < NUM_CE; e++) if (sbq[e].size() >= DEPTH) m_rdy = 1'b0;
            end else if (int'(RALU_CESEL_E_R) < NUM_CE) begin
                m_rdy = (sbq[RALU_CESEL_E_R].size() < DEPTH);
            end else begin
                m_rdy = 1'b1;
            end
            checks++;
            if (CEI_CERDY_E_R !== m_rdy) begin
                failures++;
                $display("FAIL sb_rdy t=%0t got=%b exp=%b", $time, CEI_CERDY_E_R, m_rdy);
            end
            for (int e = 0; e < NUM_CE; e++) begin
                checks++;
                if (CEI_CEVLD_E_R[e] !== (sbq[e].size() != 0)) begin
                    failures++;
                    $display("FAIL sb_vld%0d t=%0t got=%b exp=%b", e, $time, CEI_CEVLD_E_R[e], sbq[e].size() != 0);
                end
                if (sbq[e].size() != 0) begin
                    got = {CEI_INSTM32_S_R_N[e], CEI_CEOP_S_R[e*OPW +: OPW],
                           CEI_BOP_E_R[e*DW +: DW], CEI_AOP_E_R[e*DW +: DW]};
                    checks++;
                    if (got !== sbq[e][0]) begin
                        failures++;
                        $display("FAIL sb_head%0d t=%0t got=%h exp=%h", e, $time, got, sbq[e][0]);
                    end
                end
`ifdef CE_DIST_PERF_EN
                checks++;
                if (CEI_PERFCNT_R[e*CNTW +: CNTW] !== pcnt[e]) begin
                    failures++;
                    $display("FAIL sb_perf%0d got=%0d exp=%0d", e, CEI_PERFCNT_R[e*CNTW +: CNTW], pcnt[e]);
                end
`endif
            end
            checks++;
            if (CEI_CEHLW_AOP_E_R !== exp_hlw) begin
                failures++;
                $display("FAIL sb_hlw t=%0t got=%h exp=%h", $time, CEI_CEHLW_AOP_E_R, exp_hlw);
            end
            checks++;
            if (CEI_SELERR_R !== exp_selerr) begin
                failures++;
                $display("FAIL sb_selerr t=%0t got=%b exp=%b", $time, CEI_SELERR_R, exp_selerr);
            end
            for (int e = 0; e < NUM_CE; e++) begin
                if (CE_ACK_E_R[e] && sbq[e].size() != 0) begin
                    void'(sbq[e].pop_front());
                    if (pcnt[e] != '1) pcnt[e] = pcnt[e] + 1'b1;
                end
            end
            if (RALU_CEVLD_E_R && m_rdy) begin
                pl = {RALU_INSTM32_S_R_N, RALU_CEOP_S_R, RALU_CINBI_E_R, RALU_CINA_E_R};
                exp_hlw = RALU_CINA_E_R;
                if (RALU_CEBCAST_E_R) begin
                    for (int e = 0; e < NUM_CE; e++) sbq[e].push_back(pl);
                end else if (int'(RALU_CESEL_E_R) < NUM_CE) begin
                    sbq[RALU_CESEL_E_R].push_back(pl);
                end else begin
                    exp_selerr = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic vld, input logic [SELW-1:0] sel, input logic bc,
                         input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [OPW-1:0] op, input logic n32);
        RALU_CEVLD_E_R     = vld;
        RALU_CESEL_E_R     = sel;
        RALU_CEBCAST_E_R   = bc;
        RALU_CINA_E_R      = a;
        RALU_CINBI_E_R     = b;
        RALU_CEOP_S_R      = op;
        RALU_INSTM32_S_R_N = n32;
    endtask

    task automatic idle(input int n);
        drive(1'b0, '0, 1'b0, '0, '0, '0, 1'b1);
        CE_ACK_E_R = '0;
        repeat (n) tick();
    endtask

    task automatic drain();
        drive(1'b0, '0, 1'b0, '0, '0, '0, 1'b1);
        CE_ACK_E_R = '1;
        repeat (2 * DEPTH + 2) tick();
        CE_ACK_E_R = '0;
        checks++;
        if (CEI_CEVLD_E_R !== '0) begin
            failures++;
            $display("FAIL drain_vld got=%b exp=%b", CEI_CEVLD_E_R, 2'b00);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        idle(2);
        checks++;
        if ({CEI_CEVLD_E_R, CEI_CERDY_E_R, CEI_SELERR_R, CEI_INSTM32_S_R_N} !== 6'b00_1_0_11) begin
            failures++;
            $display("FAIL reset_ctl got=%b exp=%b",
                     {CEI_CEVLD_E_R, CEI_CERDY_E_R, CEI_SELERR_R, CEI_INSTM32_S_R_N}, 6'b00_1_0_11);
        end
        checks++;
        if ({CEI_CEHLW_AOP_E_R, CEI_AOP_E_R, CEI_BOP_E_R, CEI_CEOP_S_R} !== '0) begin
            failures++;
            $display("FAIL reset_data hlw=%h aop=%h bop=%h op=%h exp=0",
                     CEI_CEHLW_AOP_E_R, CEI_AOP_E_R, CEI_BOP_E_R, CEI_CEOP_S_R);
        end
        RST = 1'b0;
        tick();
    endtask

    task automatic test_route();
        drive(1'b1, 3'd1, 1'b0, 32'h11, 32'h22, 12'h0A5, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0, '0, '0, '0, 1'b1);
        checks++;
        if (CEI_CEVLD_E_R !== 2'b10) begin
            failures++;
            $display("FAIL route_vld got=%b exp=%b", CEI_CEVLD_E_R, 2'b10);
        end
        checks++;
        if ({CEI_AOP_E_R[DW +: DW], CEI_BOP_E_R[DW +: DW], CEI_CEOP_S_R[OPW +: OPW], CEI_INSTM32_S_R_N[1]}
            !== {32'h11, 32'h22, 12'h0A5, 1'b0}) begin
            failures++;
            $display("FAIL route_ce1 a=%h b=%h op=%h n32=%b exp a=11 b=22 op=0a5 n32=0",
                     CEI_AOP_E_R[DW +: DW], CEI_BOP_E_R[DW +: DW], CEI_CEOP_S_R[OPW +: OPW],
                     CEI_INSTM32_S_R_N[1]);
        end
        checks++;
        if (CEI_CEHLW_AOP_E_R !== 32'h11) begin
            failures++;
            $display("FAIL route_hlw got=%h exp=%h", CEI_CEHLW_AOP_E_R, 32'h11);
        end
        repeat (2) tick();
        checks++;
        if (CEI_CEVLD_E_R[1] !== 1'b1) begin
            failures++;
            $display("FAIL route_hold got=%b exp=1", CEI_CEVLD_E_R[1]);
        end
        drain();
    endtask

    task automatic test_fill();
        logic [2:0] rdy_seen;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 3'd0, 1'b0, 32'hA0 + k, 32'hB0 + k, OPW'(k), 1'b1);
            #1 rdy_seen[k] = CEI_CERDY_E_R;
            tick();
        end
        checks++;
        if (rdy_seen !== 3'b011) begin
            failures++;
            $display("FAIL fill_rdy_seq got=%b exp=%b", rdy_seen, 3'b011);
        end
        drive(1'b0, 3'd0, 1'b0, '0, '0, '0, 1'b1);
        CE_ACK_E_R = 2'b01;
        #1;
        checks++;
        if (CEI_CERDY_E_R !== 1'b0) begin
            failures++;
            $display("FAIL fill_rdy_full got=%b exp=0", CEI_CERDY_E_R);
        end
        tick();
        CE_ACK_E_R = 2'b00;
        #1;
        checks++;
        if ({CEI_CERDY_E_R, CEI_AOP_E_R[DW-1:0]} !== {1'b1, 32'hA1}) begin
            failures++;
            $display("FAIL fill_after_pop rdy=%b a=%h exp rdy=1 a=a1", CEI_CERDY_E_R, CEI_AOP_E_R[DW-1:0]);
        end
        drain();
    endtask

    task automatic test_bcast();
        for (int k = 0; k < DEPTH; k++) begin
            drive(1'b1, 3'd0, 1'b0, 32'hC0 + k, 32'hD0, 12'h3C, 1'b1);
            tick();
        end
        drive(1'b1, 3'd0, 1'b1, 32'hBCBC, 32'h5A5A, 12'hFFF, 1'b0);
        #1;
        checks++;
        if (CEI_CERDY_E_R !== 1'b0) begin
            failures++;
            $display("FAIL bcast_rdy_blocked got=%b exp=0", CEI_CERDY_E_R);
        end
        tick();
        checks++;
        if (CEI_CEVLD_E_R[1] !== 1'b0) begin
            failures++;
            $display("FAIL bcast_partial got=%b exp=0", CEI_CEVLD_E_R[1]);
        end
        CE_ACK_E_R = 2'b01;
        tick();
        CE_ACK_E_R = 2'b00;
        checks++;
        if (CEI_CERDY_E_R !== 1'b1) begin
            failures++;
            $display("FAIL bcast_rdy_after_pop got=%b exp=1", CEI_CERDY_E_R);
        end
        tick();
        drive(1'b0, 3'd0, 1'b0, '0, '0, '0, 1'b1);
        checks++;
        if ({CEI_CEVLD_E_R, CEI_AOP_E_R[DW +: DW], CEI_CEHLW_AOP_E_R} !== {2'b11, 32'hBCBC, 32'hBCBC}) begin
            failures++;
            $display("FAIL bcast_both vld=%b a1=%h hlw=%h exp vld=11 a1=bcbc hlw=bcbc",
                     CEI_CEVLD_E_R, CEI_AOP_E_R[DW +: DW], CEI_CEHLW_AOP_E_R);
        end
        drain();
    endtask

    task automatic test_selerr();
        checks++;
        if (CEI_SELERR_R !== 1'b0) begin
            failures++;
            $display("FAIL selerr_pre got=%b exp=0", CEI_SELERR_R);
        end
        drive(1'b1, 3'd5, 1'b0, 32'hDEAD, 32'hBEEF, 12'h123, 1'b1);
        #1;
        checks++;
        if (CEI_CERDY_E_R !== 1'b1) begin
            failures++;
            $display("FAIL selerr_rdy got=%b exp=1", CEI_CERDY_E_R);
        end
        tick();
        drive(1'b0, 3'd0, 1'b0, '0, '0, '0, 1'b1);
        repeat (3) tick();
        checks++;
        if ({CEI_SELERR_R, CEI_CEVLD_E_R, CEI_CEHLW_AOP_E_R} !== {1'b1, 2'b00, 32'hDEAD}) begin
            failures++;
            $display("FAIL selerr_sticky err=%b vld=%b hlw=%h exp err=1 vld=00 hlw=dead",
                     CEI_SELERR_R, CEI_CEVLD_E_R, CEI_CEHLW_AOP_E_R);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 300; k++) begin
            drive($urandom_range(0, 3) != 0, SELW'($urandom_range(0, 2)), $urandom_range(0, 7) == 0,
                  $urandom, $urandom, OPW'($urandom), 1'($urandom));
            CE_ACK_E_R = NUM_CE'($urandom);
            tick();
        end
        drain();
    endtask

    task automatic test_midreset();
        for (int k = 0; k < DEPTH; k++) begin
            drive(1'b1, 3'd0, 1'b0, 32'h77 + k, 32'h88, 12'h1, 1'b1);
            tick();
        end
        drive(1'b0, 3'd0, 1'b0, '0, '0, '0, 1'b1);
        #2 RST = 1'b1;
        #1;
        checks++;
        if ({CEI_CEVLD_E_R, CEI_SELERR_R, CEI_CEHLW_AOP_E_R, CEI_INSTM32_S_R_N} !== {2'b00, 1'b0, 32'h0, 2'b11}) begin
            failures++;
            $display("FAIL midreset vld=%b err=%b hlw=%h n32=%b exp vld=00 err=0 hlw=0 n32=11",
                     CEI_CEVLD_E_R, CEI_SELERR_R, CEI_CEHLW_AOP_E_R, CEI_INSTM32_S_R_N);
        end
        tick();
        RST = 1'b0;
        tick();
    endtask

`ifdef CE_DIST_PERF_EN
    task automatic test_perf();
        CE_ACK_E_R = 2'b10;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 3'd1, 1'b0, 32'h900 + k, 32'h0, 12'h0, 1'b1);
            tick();
        end
        drive(1'b0, 3'd0, 1'b0, '0, '0, '0, 1'b1);
        repeat (3) tick();
        CE_ACK_E_R = 2'b00;
        checks++;
        if ({CEI_PERFCNT_R[CNTW +: CNTW], CEI_PERFCNT_R[0 +: CNTW]} !== {CNTW'(3), CNTW'(0)}) begin
            failures++;
            $display("FAIL perf_cnt ce1=%0d ce0=%0d exp ce1=3 ce0=0",
                     CEI_PERFCNT_R[CNTW +: CNTW], CEI_PERFCNT_R[0 +: CNTW]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_route();
        test_fill();
        test_bcast();
        test_selerr();
        test_back_to_back();
        test_midreset();
`ifdef CE_DIST_PERF_EN
        test_perf();
`endif
        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
